// File: rtl/uart_feeder_pkg.sv
// ---------------------------------------------------------------------------
// uart_feeder_pkg
//   Shared definitions for the UART transmit feeder: the issue-controller
//   state encoding and the default sizing constants used by uart_tx_feeder
//   and its FIFO.
// ---------------------------------------------------------------------------
package uart_feeder_pkg;

    // Encoding is visible on the fstate port, so the values are fixed.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        GAP   = 2'd3
    } feeder_state_e;

    localparam int unsigned DEF_DEPTH     = 8;
    localparam int unsigned DEF_AW        = 3;
    localparam int unsigned DEF_MAX_RETRY = 2;
    localparam int unsigned DEF_TIMEOUT   = 1023;

endpackage

// File: rtl/uart_feeder_fifo.sv
// ---------------------------------------------------------------------------
// uart_feeder_fifo
//   DEPTH x 8 byte FIFO with synchronous write and a head-of-queue read port.
//   Pointers wrap naturally because DEPTH is a power of two.
//
// Ports:
//   clk_i    : clock, rising edge
//   rst_ni   : asynchronous active-low reset (pointers and count only)
//   push_i   : write request; ignored while full
//   wdata_i  : byte to write
//   pop_i    : discard the head entry; ignored while empty
//   rdata_o  : current head entry
//   count_o  : number of entries held (0..DEPTH)
//   full_o   : count_o == DEPTH
//   empty_o  : count_o == 0
// ---------------------------------------------------------------------------
module uart_feeder_fifo
    import uart_feeder_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned AW    = DEF_AW
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [7:0]    wdata_i,
    input  logic          pop_i,
    output logic [7:0]    rdata_o,
    output logic [AW:0]   count_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    // Full is taken from the registered count, so a push is refused while
    // full even when a pop happens in the same cycle.
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    always_comb begin
        wptr_d  = do_push ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = do_pop  ? rptr_q + AW'(1) : rptr_q;
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage is data only; emptiness is tracked by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// ---------------------------------------------------------------------------
// uart_tx_feeder
//   Byte buffer and issue controller in front of a UART transmitter. Host
//   bytes are queued in a FIFO; the FSM presents the head byte on
//   tx_data/tx_rdy, holds it until the UART completes it, re-issues it on
//   tx_error up to MAX_RETRY times, then drops it. Keeps sent/dropped counts
//   and a sticky error flag.
//
// Optional build macro: UART_FEEDER_TIMEOUT_EN
//   When defined, a 10-bit WAIT-cycle counter treats TIMEOUT cycles without
//   tx_done/tx_error exactly like a tx_error. When undefined, WAIT waits
//   indefinitely and no counter exists.
//
// Ports:
//   clka       : clock, rising edge
//   reset      : asynchronous active-low reset
//   in_data    : host byte          in_valid : host byte valid
//   in_ready   : FIFO can accept (equals !full)
//   tx_data    : byte to the UART   tx_rdy   : issue request to the UART
//   tx_busy    : UART accepted the byte
//   tx_done    : one-cycle completion pulse
//   tx_error   : UART error indication
//   fifo_count : entries held       empty/full : FIFO status
//   sent_count : completed bytes (wraps)
//   drop_count : dropped bytes (saturates at 255)
//   err        : sticky error flag  fstate   : FSM state encoding
// ---------------------------------------------------------------------------
module uart_tx_feeder
    import uart_feeder_pkg::*;
#(
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned AW        = DEF_AW,
    parameter int unsigned MAX_RETRY = DEF_MAX_RETRY,
    parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
    input  logic          clka,
    input  logic          reset,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [7:0]    tx_data,
    output logic          tx_rdy,
    input  logic          tx_busy,
    input  logic          tx_done,
    input  logic          tx_error,
    output logic [AW:0]   fifo_count,
    output logic          empty,
    output logic          full,
    output logic [15:0]   sent_count,
    output logic [7:0]    drop_count,
    output logic          err,
    output logic [1:0]    fstate
);

    localparam int unsigned RW = $clog2(MAX_RETRY + 2);

    if (DEPTH < 2 || DEPTH != (1 << AW) || TIMEOUT < 1 || TIMEOUT > 1023) begin : g_bad_cfg
        $error("uart_tx_feeder: DEPTH must equal 2**AW (>=2), TIMEOUT must be 1..1023");
    end

    feeder_state_e state_q, state_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [15:0]   sent_q, sent_d;
    logic [7:0]    drop_q, drop_d;
    logic          err_q, err_d;
    logic          pop;
    logic          fail;
    logic          tmo_hit;
    logic [7:0]    head;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    uart_feeder_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk_i   (clka),
        .rst_ni  (reset),
        .push_i  (in_valid),
        .wdata_i (in_data),
        .pop_i   (pop),
        .rdata_o (head),
        .count_o (fifo_count),
        .full_o  (full),
        .empty_o (empty)
    );

`ifdef UART_FEEDER_TIMEOUT_EN
    logic [9:0] tmo_q, tmo_d;

    // Held at zero outside WAIT, so it starts from zero on every WAIT entry.
    assign tmo_d   = (state_q == WAIT) ? tmo_q + 10'd1 : 10'd0;
    assign tmo_hit = (state_q == WAIT) && (tmo_q == 10'(TIMEOUT - 1));

    always_ff @(posedge clka or negedge reset) begin
        if (!reset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    assign fail = tx_error || tmo_hit;

    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        retry_d   = retry_q;
        sent_d    = sent_q;
        drop_d    = drop_q;
        err_d     = err_q || fail;
        pop       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    tx_data_d = head;
                    retry_d   = '0;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                // A fast UART may finish before we ever observe WAIT.
                if (tx_done) begin
                    pop     = 1'b1;
                    sent_d  = sent_q + 16'd1;
                    state_d = GAP;
                end else if (tx_busy) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Error outranks a coincident done: the byte is not counted as sent.
                if (fail) begin
                    if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d = retry_q + RW'(1);
                        state_d = ISSUE;
                    end else begin
                        pop     = 1'b1;
                        drop_d  = sat_inc8(drop_q);
                        state_d = GAP;
                    end
                end else if (tx_done) begin
                    pop     = 1'b1;
                    sent_d  = sent_q + 16'd1;
                    state_d = GAP;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clka or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            tx_data_q <= 8'h00;
            retry_q   <= '0;
            sent_q    <= '0;
            drop_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            retry_q   <= retry_d;
            sent_q    <= sent_d;
            drop_q    <= drop_d;
            err_q     <= err_d;
        end
    end

    assign in_ready   = !full;
    assign tx_rdy     = (state_q == ISSUE);
    assign tx_data    = tx_data_q;
    assign sent_count = sent_q;
    assign drop_count = drop_q;
    assign err        = err_q;
    assign fstate     = state_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
module tb_uart_tx_feeder;

    localparam int DEPTH     = 8;
    localparam int AW        = 3;
    localparam int MAX_RETRY = 2;
    localparam int TIMEOUT   = 16;

    logic          clka = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          tx_busy = 1'b0;
    logic          tx_done = 1'b0;
    logic          tx_error = 1'b0;
    logic          in_ready;
    logic [7:0]    tx_data;
    logic          tx_rdy;
    logic [AW:0]   fifo_count;
    logic          empty;
    logic          full;
    logic [15:0]   sent_count;
    logic [7:0]    drop_count;
    logic          err;
    logic [1:0]    fstate;

    int n_checks = 0;
    int n_errors = 0;

    // Transaction-level reference: queued bytes plus expected statistics.
    logic [7:0] mq[$];
    int         exp_sent;
    int         exp_drop;
    bit         exp_err;

    always #5 clka = ~clka;

    uart_tx_feeder #(
        .DEPTH(DEPTH), .AW(AW), .MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT)
    ) dut (
        .clka(clka), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .tx_data(tx_data), .tx_rdy(tx_rdy),
        .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error),
        .fifo_count(fifo_count), .empty(empty), .full(full),
        .sent_count(sent_count), .drop_count(drop_count),
        .err(err), .fstate(fstate)
    );

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; tx_busy = 1'b0; tx_done = 1'b0; tx_error = 1'b0;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        mq.delete();
        exp_sent = 0; exp_drop = 0; exp_err = 1'b0;
    endtask

    // Host push for one cycle; the model accepts it only while it has room.
    task automatic push_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
        if (mq.size() < DEPTH) mq.push_back(b);
    endtask

    task automatic wait_rdy(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (tx_rdy === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        #3 reset = 1'b0;
        #1;
        n_checks++;
        if ({tx_rdy, tx_data, in_ready, empty, full, fifo_count, sent_count, drop_count, err, fstate} !==
            {1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'd0, 16'd0, 8'd0, 1'b0, 2'd0}) begin
            n_errors++;
            $display("FAIL reset_values: got rdy=%b data=%h in_rdy=%b empty=%b full=%b cnt=%0d sent=%0d drop=%0d err=%b st=%0d, want 0 00 1 1 0 0 0 0 0 0",
                     tx_rdy, tx_data, in_ready, empty, full, fifo_count, sent_count, drop_count, err, fstate);
        end
        tick();
        tick();
        reset = 1'b1;
        tick();
        n_checks++;
        if ({tx_rdy, fstate, fifo_count} !== {1'b0, 2'd0, 4'd0}) begin
            n_errors++;
            $display("FAIL reset_release: got rdy=%b st=%0d cnt=%0d, want 0 0 0", tx_rdy, fstate, fifo_count);
        end
    endtask

    task automatic test_single();
        do_reset();
        push_byte(8'hA5);
        n_checks++;
        if ({fifo_count, tx_rdy, fstate} !== {4'd1, 1'b0, 2'd0}) begin
            n_errors++;
            $display("FAIL single_push: got cnt=%0d rdy=%b st=%0d, want 1 0 0", fifo_count, tx_rdy, fstate);
        end
        tick();
        n_checks++;
        if ({tx_rdy, tx_data, fstate} !== {1'b1, 8'hA5, 2'd1}) begin
            n_errors++;
            $display("FAIL single_issue: got rdy=%b data=%h st=%0d, want 1 a5 1", tx_rdy, tx_data, fstate);
        end
        tx_busy = 1'b1; tick(); tx_busy = 1'b0;
        n_checks++;
        if ({fstate, tx_rdy, tx_data} !== {2'd2, 1'b0, 8'hA5}) begin
            n_errors++;
            $display("FAIL single_wait: got st=%0d rdy=%b data=%h, want 2 0 a5", fstate, tx_rdy, tx_data);
        end
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        n_checks++;
        if ({fstate, sent_count, empty, fifo_count} !== {2'd3, 16'd1, 1'b1, 4'd0}) begin
            n_errors++;
            $display("FAIL single_done: got st=%0d sent=%0d empty=%b cnt=%0d, want 3 1 1 0", fstate, sent_count, empty, fifo_count);
        end
        tick();
        n_checks++;
        if ({fstate, tx_rdy} !== {2'd0, 1'b0}) begin
            n_errors++;
            $display("FAIL single_idle: got st=%0d rdy=%b, want 0 0", fstate, tx_rdy);
        end
    endtask

    task automatic test_fill();
        bit ok;
        do_reset();
        for (int i = 0; i < DEPTH; i++) push_byte(8'(i));
        n_checks++;
        if ({full, in_ready, fifo_count} !== {1'b1, 1'b0, 4'd8}) begin
            n_errors++;
            $display("FAIL fill_full: got full=%b in_rdy=%b cnt=%0d, want 1 0 8", full, in_ready, fifo_count);
        end
        push_byte(8'hEE);
        n_checks++;
        if ({full, fifo_count} !== {1'b1, 4'd8}) begin
            n_errors++;
            $display("FAIL fill_ninth: got full=%b cnt=%0d, want 1 8", full, fifo_count);
        end
        while (mq.size() > 0) begin
            wait_rdy(ok);
            n_checks++;
            if (!ok || tx_data !== mq[0]) begin
                n_errors++;
                $display("FAIL fill_order: got rdy=%b data=%h, want 1 %h", ok, tx_data, mq[0]);
                return;
            end
            tx_done = 1'b1; tick(); tx_done = 1'b0;
            void'(mq.pop_front());
            exp_sent++;
        end
        n_checks++;
        if ({fifo_count, empty, sent_count} !== {4'd0, 1'b1, 16'(exp_sent)}) begin
            n_errors++;
            $display("FAIL fill_drain: got cnt=%0d empty=%b sent=%0d, want 0 1 %0d", fifo_count, empty, sent_count, exp_sent);
        end
    endtask

    task automatic test_full_push_pop();
        bit ok;
        logic [7:0] x;
        do_reset();
        for (int i = 0; i < DEPTH; i++) push_byte(8'($urandom));
        n_checks++;
        if ({full, tx_rdy, tx_data} !== {1'b1, 1'b1, mq[0]}) begin
            n_errors++;
            $display("FAIL fpp_setup: got full=%b rdy=%b data=%h, want 1 1 %h", full, tx_rdy, tx_data, mq[0]);
        end
        // Full: push refused although the head completes in the same cycle.
        x = 8'($urandom);
        in_valid = 1'b1; in_data = x; tx_done = 1'b1;
        tick();
        in_valid = 1'b0; tx_done = 1'b0;
        void'(mq.pop_front()); exp_sent++;
        n_checks++;
        if ({fifo_count, full, sent_count} !== {4'd7, 1'b0, 16'd1}) begin
            n_errors++;
            $display("FAIL fpp_refused: got cnt=%0d full=%b sent=%0d, want 7 0 1", fifo_count, full, sent_count);
        end
        // Not full: push and pop together leave the count unchanged.
        wait_rdy(ok);
        x = 8'($urandom);
        in_valid = 1'b1; in_data = x; tx_done = 1'b1;
        tick();
        in_valid = 1'b0; tx_done = 1'b0;
        void'(mq.pop_front()); mq.push_back(x); exp_sent++;
        n_checks++;
        if ({ok, fifo_count} !== {1'b1, 4'd7}) begin
            n_errors++;
            $display("FAIL fpp_both: got rdy_seen=%b cnt=%0d, want 1 7", ok, fifo_count);
        end
        while (mq.size() > 0) begin
            wait_rdy(ok);
            n_checks++;
            if (!ok || tx_data !== mq[0]) begin
                n_errors++;
                $display("FAIL fpp_order: got rdy=%b data=%h, want 1 %h", ok, tx_data, mq[0]);
                return;
            end
            tx_done = 1'b1; tick(); tx_done = 1'b0;
            void'(mq.pop_front());
            exp_sent++;
        end
        n_checks++;
        if ({fifo_count, sent_count} !== {4'd0, 16'(exp_sent)}) begin
            n_errors++;
            $display("FAIL fpp_drain: got cnt=%0d sent=%0d, want 0 %0d", fifo_count, sent_count, exp_sent);
        end
    endtask

    task automatic test_retry_drop();
        bit ok;
        int extra;
        do_reset();
        push_byte(8'h3C);
        for (int a = 0; a <= MAX_RETRY; a++) begin
            wait_rdy(ok);
            n_checks++;
            if (!ok || tx_data !== 8'h3C) begin
                n_errors++;
                $display("FAIL retry_issue%0d: got rdy=%b data=%h, want 1 3c", a, ok, tx_data);
                return;
            end
            tx_busy = 1'b1; tick(); tx_busy = 1'b0;
            tx_error = 1'b1; tick(); tx_error = 1'b0;
            if (a < MAX_RETRY) begin
                n_checks++;
                if ({tx_rdy, err, fifo_count} !== {1'b1, 1'b1, 4'd1}) begin
                    n_errors++;
                    $display("FAIL retry_reissue%0d: got rdy=%b err=%b cnt=%0d, want 1 1 1", a, tx_rdy, err, fifo_count);
                end
            end
        end
        n_checks++;
        if ({drop_count, err, sent_count, fifo_count, fstate} !== {8'd1, 1'b1, 16'd0, 4'd0, 2'd3}) begin
            n_errors++;
            $display("FAIL retry_drop: got drop=%0d err=%b sent=%0d cnt=%0d st=%0d, want 1 1 0 0 3",
                     drop_count, err, sent_count, fifo_count, fstate);
        end
        extra = 0;
        repeat (8) begin
            tick();
            if (tx_rdy === 1'b1) extra++;
        end
        n_checks++;
        if (extra != 0) begin
            n_errors++;
            $display("FAIL retry_no_fourth: got %0d extra issue cycles, want 0", extra);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        for (int i = 0; i < 5; i++) push_byte(8'($urandom));
        wait_rdy(ok);
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        wait_rdy(ok);
        tx_busy = 1'b1; tick(); tx_busy = 1'b0;
        tx_error = 1'b1; tick(); tx_error = 1'b0;
        wait_rdy(ok);
        tx_busy = 1'b1; tick(); tx_busy = 1'b0;
        n_checks++;
        if ({fstate, fifo_count, sent_count, err} !== {2'd2, 4'd4, 16'd1, 1'b1}) begin
            n_errors++;
            $display("FAIL mid_setup: got st=%0d cnt=%0d sent=%0d err=%b, want 2 4 1 1", fstate, fifo_count, sent_count, err);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({tx_rdy, tx_data, in_ready, empty, full, fifo_count, sent_count, drop_count, err, fstate} !==
            {1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'd0, 16'd0, 8'd0, 1'b0, 2'd0}) begin
            n_errors++;
            $display("FAIL mid_async: got rdy=%b data=%h in_rdy=%b empty=%b full=%b cnt=%0d sent=%0d drop=%0d err=%b st=%0d",
                     tx_rdy, tx_data, in_ready, empty, full, fifo_count, sent_count, drop_count, err, fstate);
        end
        tick();
        reset = 1'b1;
        mq.delete();
        repeat (3) tick();
        n_checks++;
        if ({tx_rdy, fifo_count, fstate} !== {1'b0, 4'd0, 2'd0}) begin
            n_errors++;
            $display("FAIL mid_after: got rdy=%b cnt=%0d st=%0d, want 0 0 0", tx_rdy, fifo_count, fstate);
        end
    endtask

    task automatic test_random();
        bit ok;
        int mode, d, n, retry;
        do_reset();
        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) begin
                n_checks++;
                if (in_ready !== (mq.size() < DEPTH)) begin
                    n_errors++;
                    $display("FAIL rand_in_ready: got %b with %0d queued", in_ready, mq.size());
                end
                push_byte(8'($urandom));
            end
            retry = 0;
            while (mq.size() > 0) begin
                wait_rdy(ok);
                n_checks++;
                if (!ok || tx_data !== mq[0]) begin
                    n_errors++;
                    $display("FAIL rand_issue: got rdy=%b data=%h, want 1 %h", ok, tx_data, mq[0]);
                    return;
                end
                mode = $urandom_range(0, 3);
                if (mode == 0) begin
                    tx_done = 1'b1; tick(); tx_done = 1'b0;
                    void'(mq.pop_front()); exp_sent++; retry = 0;
                end else begin
                    tx_busy = 1'b1; tick(); tx_busy = 1'b0;
                    d = $urandom_range(0, 3);
                    repeat (d) tick();
                    n_checks++;
                    if ({tx_rdy, tx_data} !== {1'b0, mq[0]}) begin
                        n_errors++;
                        $display("FAIL rand_hold: got rdy=%b data=%h, want 0 %h", tx_rdy, tx_data, mq[0]);
                    end
                    if (mode == 3) begin
                        tx_error = 1'b1;
                        tx_done  = 1'($urandom_range(0, 1));
                    end else begin
                        tx_done = 1'b1;
                    end
                    tick();
                    tx_error = 1'b0; tx_done = 1'b0;
                    if (mode == 3) begin
                        exp_err = 1'b1;
                        if (retry < MAX_RETRY) begin
                            retry++;
                        end else begin
                            void'(mq.pop_front());
                            exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
                            retry = 0;
                        end
                    end else begin
                        void'(mq.pop_front()); exp_sent++; retry = 0;
                    end
                end
                n_checks++;
                if ({sent_count, drop_count, err, fifo_count} !==
                    {16'(exp_sent), 8'(exp_drop), exp_err, (AW+1)'(mq.size())}) begin
                    n_errors++;
                    $display("FAIL rand_stats: got sent=%0d drop=%0d err=%b cnt=%0d, want %0d %0d %b %0d",
                             sent_count, drop_count, err, fifo_count, exp_sent, exp_drop, exp_err, mq.size());
                end
            end
            repeat ($urandom_range(0, 3)) tick();
        end
    endtask

    task automatic test_drop_saturation();
        bit ok;
        do_reset();
        for (int i = 0; i < 257; i++) begin
            push_byte(8'($urandom));
            for (int a = 0; a <= MAX_RETRY; a++) begin
                wait_rdy(ok);
                if (!ok) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sat_issue: no tx_rdy on byte %0d attempt %0d", i, a);
                    return;
                end
                tx_busy = 1'b1; tick(); tx_busy = 1'b0;
                tx_error = 1'b1; tick(); tx_error = 1'b0;
            end
            exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
            if (i == 254 || i == 256) begin
                n_checks++;
                if ({drop_count, sent_count} !== {8'(exp_drop), 16'd0}) begin
                    n_errors++;
                    $display("FAIL sat_drop%0d: got drop=%0d sent=%0d, want %0d 0", i, drop_count, sent_count, exp_drop);
                end
            end
        end
    endtask

`ifdef UART_FEEDER_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        int n;
        do_reset();
        push_byte(8'h5A);
        wait_rdy(ok);
        tx_busy = 1'b1; tick(); tx_busy = 1'b0;
        n = 0;
        while (fstate === 2'd2 && n < 100) begin
            tick();
            n++;
        end
        n_checks++;
        if ({ok, err, tx_rdy, tx_data, fifo_count} !== {1'b1, 1'b1, 1'b1, 8'h5A, 4'd1} || n != TIMEOUT) begin
            n_errors++;
            $display("FAIL timeout_retry: got wait=%0d err=%b rdy=%b data=%h cnt=%0d, want %0d 1 1 5a 1",
                     n, err, tx_rdy, tx_data, fifo_count, TIMEOUT);
        end
    endtask
`else
    task automatic test_timeout();
        bit ok;
        do_reset();
        push_byte(8'h5A);
        wait_rdy(ok);
        tx_busy = 1'b1; tick(); tx_busy = 1'b0;
        repeat (100) tick();
        n_checks++;
        if ({ok, fstate, err, tx_rdy, fifo_count} !== {1'b1, 2'd2, 1'b0, 1'b0, 4'd1}) begin
            n_errors++;
            $display("FAIL no_timeout: got rdy_seen=%b st=%0d err=%b rdy=%b cnt=%0d, want 1 2 0 0 1",
                     ok, fstate, err, tx_rdy, fifo_count);
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_full_push_pop();
        test_retry_drop();
        test_reset_mid();
        test_random();
        test_drop_saturation();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
